// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-look-ahead adder/subtractor: one DATA_WID/STAGES-bit segment per stage, valid/ready flow.
// Define CLA_OVF_EN to add the registered signed-overflow output port.
module pipelined_cla_adder #(
  parameter int DATA_WID  = 16,
  parameter int STAGES    = 4,
  parameter int BLOCK_WID = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_WID-1:0] in1,
  input  logic [DATA_WID-1:0] in2,
  input  logic                carry_in,
  input  logic                sub,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_WID-1:0] sum,
`ifdef CLA_OVF_EN
  output logic                overflow,
`endif
  output logic                carry_out
);

  localparam int SEG  = DATA_WID / STAGES;
  localparam int NBLK = SEG / BLOCK_WID;

  // Carry into bit j of a look-ahead group, written as a flat sum of products.
  function automatic logic la_carry(input logic [BLOCK_WID-1:0] p,
                                    input logic [BLOCK_WID-1:0] g,
                                    input logic                 cin,
                                    input int                   j);
    logic c;
    logic pp;
    c  = 1'b0;
    pp = 1'b1;
    for (int i = BLOCK_WID - 1; i >= 0; i--) begin
      if (i < j) begin
        c  = c | (pp & g[i]);
        pp = pp & p[i];
      end
    end
    return c | (pp & cin);
  endfunction

  // One segment: groups resolve internally, group carries chain via group generate/propagate.
  function automatic logic [SEG:0] seg_add(input logic [SEG-1:0] a,
                                           input logic [SEG-1:0] b,
                                           input logic           cin);
    logic [SEG-1:0]       s;
    logic [BLOCK_WID-1:0] p;
    logic [BLOCK_WID-1:0] g;
    logic                 c;
    s = '0;
    c = cin;
    for (int k = 0; k < NBLK; k++) begin
      p = a[k*BLOCK_WID +: BLOCK_WID] ^ b[k*BLOCK_WID +: BLOCK_WID];
      g = a[k*BLOCK_WID +: BLOCK_WID] & b[k*BLOCK_WID +: BLOCK_WID];
      for (int j = 0; j < BLOCK_WID; j++) begin
        s[k*BLOCK_WID + j] = p[j] ^ la_carry(p, g, c, j);
      end
      c = la_carry(p, g, c, BLOCK_WID);
    end
    return {c, s};
  endfunction

  logic [STAGES-1:0] vld;
  logic [STAGES:0]   vchain;
  logic [STAGES:0]   en;

  assign vchain = {vld, in_valid};

  // A stage may load if it is empty or its successor loads; this collapses bubbles.
  always_comb begin
    en[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      en[k] = ~vld[k] | en[k+1];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (en[k]) vld[k] <= vchain[k];
      end
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = k * SEG;

    logic [DATA_WID-1:0] a_in;
    logic [DATA_WID-1:0] b_in;
    logic                c_in;
    logic [DATA_WID-1:0] acc_nx;
    logic [SEG:0]        res;
    logic [DATA_WID-1:0] acc_q;
    logic [DATA_WID-1:0] bop_q;
    logic                cy_q;

    // acc carries finished sum bits below the current segment and raw A bits above it.
    if (k == 0) begin : g_src
      assign a_in = in1;
      assign b_in = in2 ^ {DATA_WID{sub}};
      assign c_in = carry_in ^ sub;
    end else begin : g_src
      assign a_in = g_stage[k-1].acc_q;
      assign b_in = g_stage[k-1].bop_q;
      assign c_in = g_stage[k-1].cy_q;
    end

    always_comb begin
      // NOTE: every output of this block gets a full default first so no latch is inferred.
      acc_nx            = a_in;
      res               = seg_add(a_in[LO +: SEG], b_in[LO +: SEG], c_in);
      acc_nx[LO +: SEG] = res[SEG-1:0];
    end

    // NOTE: datapath registers are reset too, so no stale partial result is visible after rst.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        acc_q <= '0;
        bop_q <= '0;
        cy_q  <= 1'b0;
      end else if (en[k] && vchain[k]) begin
        acc_q <= acc_nx;
        bop_q <= b_in;
        cy_q  <= res[SEG];
      end
    end
  end

  assign in_ready  = en[0];
  assign out_valid = vld[STAGES-1];
  assign sum       = g_stage[STAGES-1].acc_q;
  assign carry_out = g_stage[STAGES-1].cy_q;

`ifdef CLA_OVF_EN
  logic ovf_q;

  // Carry into the MSB is recovered as a ^ b ^ s at that bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (en[STAGES-1] && vchain[STAGES-1]) begin
      ovf_q <= g_stage[STAGES-1].a_in[DATA_WID-1] ^ g_stage[STAGES-1].b_in[DATA_WID-1] ^
               g_stage[STAGES-1].acc_nx[DATA_WID-1] ^ g_stage[STAGES-1].res[SEG];
    end
  end

  assign overflow = ovf_q;
`endif

endmodule
